// File: rtl/jacobian_fwd_mult.sv
// Forward Jacobian product [dx dy] = [A B; C D] x [dth1 dth2] using one shared,
// time-multiplexed signed 24x9 multiplier, followed by rounding and saturation to 14 bits.
module jacobian_fwd_mult #(
  parameter int FRAC_BITS = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [23:0] jacA,
  input  logic signed [23:0] jacB,
  input  logic signed [23:0] jacC,
  input  logic signed [23:0] jacD,
  input  logic signed [8:0]  dth1,
  input  logic signed [8:0]  dth2,
  output logic               busy,
  output logic               data_ready,
  output logic signed [13:0] dx,
  output logic signed [13:0] dy,
  output logic               saturated
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_X1,
    S_X2,
    S_Y1,
    S_Y2,
    S_OUT
  } state_e;

  localparam logic signed [34:0] HALF = 35'sd1 <<< (FRAC_BITS - 1);

  state_e             state_q;
  logic signed [23:0] a_q, b_q, c_q, d_q;
  logic signed [8:0]  t1_q, t2_q;
  logic signed [33:0] accx_q, accy_q;
  logic               busy_q, ready_q, sat_q;
  logic signed [13:0] dx_q, dy_q;

  logic signed [23:0] mul_a;
  logic signed [8:0]  mul_b;
  logic signed [32:0] prod;
  logic signed [33:0] prod_ext;
  logic [14:0]        scx, scy;

  // Rounds half toward +inf, then clamps; bit 14 of the result flags a clamp.
  function automatic logic [14:0] scale_sat(input logic signed [33:0] acc);
    logic signed [34:0] r;
    r = $signed({acc[33], acc}) + HALF;
    r = r >>> FRAC_BITS;
    if (r > 35'sd8191)
      return {1'b1, 14'h1FFF};
    else if (r < -35'sd8192)
      return {1'b1, 14'h2000};
    else
      return {1'b0, r[13:0]};
  endfunction

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_X1:    begin mul_a = a_q; mul_b = t1_q; end
      S_X2:    begin mul_a = b_q; mul_b = t2_q; end
      S_Y1:    begin mul_a = c_q; mul_b = t1_q; end
      S_Y2:    begin mul_a = d_q; mul_b = t2_q; end
      default: begin mul_a = '0;  mul_b = '0;   end
    endcase
    prod     = 33'(mul_a) * 33'(mul_b);
    prod_ext = {prod[32], prod};
    scx      = scale_sat(accx_q);
    scy      = scale_sat(accy_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      accx_q  <= '0;
      accy_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      sat_q   <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // busy stays high through the data_ready cycle, then follows enable.
          busy_q <= enable;
          if (enable) begin
            a_q     <= jacA;
            b_q     <= jacB;
            c_q     <= jacC;
            d_q     <= jacD;
            t1_q    <= dth1;
            t2_q    <= dth2;
            state_q <= S_X1;
          end
        end
        S_X1: begin
          accx_q  <= prod_ext;
          state_q <= S_X2;
        end
        S_X2: begin
          accx_q  <= accx_q + prod_ext;
          state_q <= S_Y1;
        end
        S_Y1: begin
          accy_q  <= prod_ext;
          state_q <= S_Y2;
        end
        S_Y2: begin
          accy_q  <= accy_q + prod_ext;
          state_q <= S_OUT;
        end
        S_OUT: begin
          dx_q    <= scx[13:0];
          dy_q    <= scy[13:0];
          sat_q   <= scx[14] | scy[14];
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign data_ready = ready_q;
  assign dx         = dx_q;
  assign dy         = dy_q;
  assign saturated  = sat_q;

endmodule

// File: tb/tb_jacobian_fwd_mult.sv
// Directed and randomized checks of jacobian_fwd_mult against an integer reference model.
module tb_jacobian_fwd_mult;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [23:0] jA, jB, jC, jD;
  logic signed [8:0]  t1, t2;
  logic               busy, data_ready, saturated;
  logic signed [13:0] dx, dy;

  int n_cmp = 0;
  int n_err = 0;

  jacobian_fwd_mult #(.FRAC_BITS(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .jacA       (jA),
    .jacB       (jB),
    .jacC       (jC),
    .jacD       (jD),
    .dth1       (t1),
    .dth2       (t2),
    .busy       (busy),
    .data_ready (data_ready),
    .dx         (dx),
    .dy         (dy),
    .saturated  (saturated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: real product sum, floor((p + 2^11) / 2^12), clamp to 14-bit signed range.
  function automatic longint scl(input longint p, output bit s);
    longint r;
    r = (p + 2048) >>> 12;
    s = 1'b0;
    if (r > 8191) begin r = 8191; s = 1'b1; end
    if (r < -8192) begin r = -8192; s = 1'b1; end
    return r;
  endfunction

  task automatic model(input longint a, b, c, d, p1, p2,
                       output longint ex, output longint ey, output bit es);
    bit sx, sy;
    ex = scl(a * p1 + b * p2, sx);
    ey = scl(c * p1 + d * p2, sy);
    es = sx | sy;
  endtask

  task automatic set_in(input longint a, b, c, d, p1, p2);
    jA = 24'(a); jB = 24'(b); jC = 24'(c); jD = 24'(d);
    t1 = 9'(p1); t2 = 9'(p2);
  endtask

  task automatic scramble();
    jA = 24'($urandom); jB = 24'($urandom); jC = 24'($urandom); jD = 24'($urandom);
    t1 = 9'($urandom); t2 = 9'($urandom);
  endtask

  // One transaction from IDLE; inputs and enable are disturbed while busy.
  task automatic run_txn(input string tag, input longint a, b, c, d, p1, p2);
    longint ex, ey;
    bit es;
    int cyc;
    model(a, b, c, d, p1, p2, ex, ey, es);
    set_in(a, b, c, d, p1, p2);
    enable = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".busy_e0"}, busy, 1);
    scramble();
    enable = 1'($urandom);
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      cyc = i;
      if (i < 5) begin scramble(); enable = 1'($urandom); end
      else enable = 1'b0;
      if (data_ready) break;
    end
    enable = 1'b0;
    chk({tag, ".latency"}, cyc, 5);
    chk({tag, ".dx"}, dx, ex);
    chk({tag, ".dy"}, dy, ey);
    chk({tag, ".sat"}, saturated, es);
    chk({tag, ".busy_rdy"}, busy, 1);
    @(posedge clk); #1;
    chk({tag, ".rdy_pulse"}, data_ready, 0);
    chk({tag, ".busy_off"}, busy, 0);
    chk({tag, ".dx_hold"}, dx, ex);
  endtask

  initial begin
    longint ex, ey;
    bit es;
    longint bb[3][6];
    longint bx[3], by[3];
    bit bs[3];
    int k, cnt;

    reset = 1'b1;
    enable = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.rdy", data_ready, 0);
    chk("rst.dx", dx, 0);
    chk("rst.dy", dy, 0);
    chk("rst.sat", saturated, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn("ident", 4096, 0, 0, 4096, 100, -50);
    chk("ident.dx_c", dx, 100);
    run_txn("cross", 8192, -4096, 2048, 12288, 10, 4);
    chk("cross.dy_c", dy, 17);
    run_txn("rnd_p3", 2048, 0, 0, 0, 3, 0);
    chk("rnd_p3.c", dx, 2);
    run_txn("rnd_m3", 2048, 0, 0, 0, -3, 0);
    chk("rnd_m3.c", dx, -1);
    run_txn("rnd_p1", 2048, 0, 0, 0, 1, 0);
    chk("rnd_p1.c", dx, 1);
    run_txn("sat_hi", 409600, 0, 0, 0, 255, 0);
    chk("sat_hi.c", dx, 8191);
    run_txn("sat_lo", 409600, 0, 0, 0, -256, 0);
    chk("sat_lo.c", dx, -8192);
    run_txn("extreme", -8388608, -8388608, 8388607, -8388608, -256, -256);

    // Abort in Y1: previous result is non-zero, so reset must visibly clear it.
    run_txn("pre_abort", 4096, 4096, -4096, 8192, 50, 20);
    set_in(4096, 0, 0, 4096, 7, 9);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    scramble();
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.rdy", data_ready, 0);
    chk("abort.dx", dx, 0);
    chk("abort.dy", dy, 0);
    chk("abort.sat", saturated, 0);
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (data_ready) cnt++;
    end
    chk("abort.no_rdy", cnt, 0);
    chk("abort.dx_after", dx, 0);
    run_txn("post_abort", -4096, 2048, 1000, -3000, -77, 33);

    // Back-to-back with enable held: E0 at cycles 0, 6, 12.
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < 4; j++) bb[t][j] = longint'($signed(24'($urandom_range(0, 24'hFFFFFF))));
      for (int j = 4; j < 6; j++) bb[t][j] = longint'($signed(9'($urandom_range(0, 511))));
      model(bb[t][0], bb[t][1], bb[t][2], bb[t][3], bb[t][4], bb[t][5], bx[t], by[t], bs[t]);
    end
    bb[1][0] = 20000; bb[1][1] = -12345; bb[1][2] = 777; bb[1][3] = 4096;
    model(bb[1][0], bb[1][1], bb[1][2], bb[1][3], bb[1][4], bb[1][5], bx[1], by[1], bs[1]);
    set_in(bb[0][0], bb[0][1], bb[0][2], bb[0][3], bb[0][4], bb[0][5]);
    enable = 1'b1;
    @(posedge clk); #1;
    set_in(bb[1][0], bb[1][1], bb[1][2], bb[1][3], bb[1][4], bb[1][5]);
    k = 0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      if (data_ready) begin
        if (k < 3) begin
          chk($sformatf("b2b%0d.cycle", k), c, 5 + 6 * k);
          chk($sformatf("b2b%0d.dx", k), dx, bx[k]);
          chk($sformatf("b2b%0d.dy", k), dy, by[k]);
          chk($sformatf("b2b%0d.sat", k), saturated, bs[k]);
        end
        k++;
      end
      if (c == 6) set_in(bb[2][0], bb[2][1], bb[2][2], bb[2][3], bb[2][4], bb[2][5]);
      if (c == 12) begin enable = 1'b0; scramble(); end
    end
    chk("b2b.count", k, 3);
    chk("b2b.busy_end", busy, 0);

    // Random transactions: half with small coefficients to exercise the non-saturated range.
    for (int r = 0; r < 24; r++) begin
      longint a, b, c, d;
      if (r % 2 == 0) begin
        a = longint'($urandom_range(0, 65535)) - 32768;
        b = longint'($urandom_range(0, 65535)) - 32768;
        c = longint'($urandom_range(0, 65535)) - 32768;
        d = longint'($urandom_range(0, 65535)) - 32768;
      end else begin
        a = longint'($urandom_range(0, 24'hFFFFFF)) - 8388608;
        b = longint'($urandom_range(0, 24'hFFFFFF)) - 8388608;
        c = longint'($urandom_range(0, 24'hFFFFFF)) - 8388608;
        d = longint'($urandom_range(0, 24'hFFFFFF)) - 8388608;
      end
      run_txn($sformatf("rand%0d", r), a, b, c, d,
              longint'($urandom_range(0, 511)) - 256,
              longint'($urandom_range(0, 511)) - 256);
    end

    model(4096, 0, 0, 4096, 100, -50, ex, ey, es);
    chk("model.ident", ex, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
